// File: rtl/mult16_share_arbiter_if.sv
// Handshake and result bus between the two calculator requesters
// (keypad/ALU sequencing) and the shared 16x16 multiplier arbiter.
interface mult16_share_arbiter_if;
    // Requester 0 request channel
    logic        req0_valid;
    logic        req0_ready;
    logic [15:0] req0_a;
    logic [15:0] req0_b;

    // Requester 1 request channel
    logic        req1_valid;
    logic        req1_ready;
    logic [15:0] req1_a;
    logic [15:0] req1_b;

    // Response channels; the product bus is shared and tagged by which valid is high
    logic        resp0_valid;
    logic        resp0_ready;
    logic        resp1_valid;
    logic        resp1_ready;
    logic [31:0] resp_product;

    // Status
    logic        busy;
    logic [15:0] op_count;

    // Requester side (front-end)
    modport master (
        output req0_valid, req0_a, req0_b, resp0_ready,
        output req1_valid, req1_a, req1_b, resp1_ready,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp1_valid, resp_product,
        input  busy, op_count
    );

    // Arbiter side
    modport slave (
        input  req0_valid, req0_a, req0_b, resp0_ready,
        input  req1_valid, req1_a, req1_b, resp1_ready,
        output req0_ready, req1_ready,
        output resp0_valid, resp1_valid, resp_product,
        output busy, op_count
    );
endinterface

// File: rtl/mult16_share_arbiter.sv
// Shares one combinational 16x16 unsigned multiplier between two requesters.
// A round-robin arbiter picks one request in IDLE, the operands are registered
// and held for MUL_LATENCY cycles while the multiplier settles, and the product
// is then captured and held in DONE until the owning requester acknowledges it.

// Combinational unsigned 16x16 -> 32 multiplier.
module Multiplier_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);
    // Operands are widened first so the product keeps all 32 bits.
    assign p = {16'd0, a} * {16'd0, b};
endmodule

module mult16_share_arbiter #(
    // Cycles the operands are held before the product is captured; legal 1..15.
    parameter int unsigned MUL_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mult16_share_arbiter_if.slave   bus
);

    localparam logic [3:0] LAT_RELOAD = 4'(MUL_LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic        owner_q;       // requester that owns the in-flight operation
    logic        last_grant_q;  // requester served most recently
    logic [15:0] op_a_q;
    logic [15:0] op_b_q;
    logic [3:0]  settle_cnt_q;
    logic [31:0] product_q;
    logic [15:0] op_count_q;
    logic        busy_q;
    logic        resp0_valid_q;
    logic        resp1_valid_q;

    logic        grant_valid;
    logic        grant_id;
    logic [15:0] sel_a;
    logic [15:0] sel_b;
    logic [31:0] mul_p;
    logic        owner_ack;

    // Round-robin grant: a lone request wins outright; on contention the
    // requester that was not served last wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned and infers a latch.
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (state_q == ST_IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = ~last_grant_q;
            end else if (bus.req0_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end else if (bus.req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end
    end

    // Request ready is combinational so the accept happens on the same edge
    // the grant is decided; at most one of the two can be high.
    assign bus.req0_ready = grant_valid & ~grant_id;
    assign bus.req1_ready = grant_valid &  grant_id;

    assign sel_a = grant_id ? bus.req1_a : bus.req0_a;
    assign sel_b = grant_id ? bus.req1_b : bus.req0_b;

    // Only the owner's acknowledge can retire the held product.
    assign owner_ack = owner_q ? bus.resp1_ready : bus.resp0_ready;

    Multiplier_16 u_mul (
        .a (op_a_q),
        .b (op_b_q),
        .p (mul_p)
    );

    // Arbiter FSM: accept in IDLE, count down the settle time in BUSY,
    // hold the product in DONE until the owner acknowledges.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples the values from before this edge.
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            owner_q       <= 1'b0;
            last_grant_q  <= 1'b1;  // requester 0 wins the first contention
            op_a_q        <= 16'd0;
            op_b_q        <= 16'd0;
            settle_cnt_q  <= 4'd0;
            product_q     <= 32'd0;
            op_count_q    <= 16'd0;
            busy_q        <= 1'b0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_valid) begin
                        op_a_q       <= sel_a;
                        op_b_q       <= sel_b;
                        owner_q      <= grant_id;
                        settle_cnt_q <= LAT_RELOAD;
                        busy_q       <= 1'b1;
                        state_q      <= ST_BUSY;
                    end
                end

                ST_BUSY: begin
                    settle_cnt_q <= settle_cnt_q - 4'd1;
                    if (settle_cnt_q == 4'd1) begin
                        product_q     <= mul_p;
                        resp0_valid_q <= ~owner_q;
                        resp1_valid_q <=  owner_q;
                        state_q       <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    if (owner_ack) begin
                        last_grant_q  <= owner_q;
                        op_count_q    <= op_count_q + 16'd1;
                        resp0_valid_q <= 1'b0;
                        resp1_valid_q <= 1'b0;
                        busy_q        <= 1'b0;
                        state_q       <= ST_IDLE;
                    end
                end

                default: begin
                    resp0_valid_q <= 1'b0;
                    resp1_valid_q <= 1'b0;
                    busy_q        <= 1'b0;
                    state_q       <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.resp0_valid  = resp0_valid_q;
    assign bus.resp1_valid  = resp1_valid_q;
    assign bus.resp_product = product_q;
    assign bus.busy         = busy_q;
    assign bus.op_count     = op_count_q;

endmodule
